lane_skid_pipe_reg: RTL and testbench
=====================================

// Module: lane_skid_pipe_reg
// PURPOSE
// - Generalised inter-stage pipeline register for the dual-issue core (IF/ID ... MEM/WB).
// - Moves a bundle of LANES instruction slots per transfer using a valid/ready handshake.
// - 2-entry skid buffer: in_ready is registered, so backpressure never combinationally crosses a stage.
// - Compacts valid slots toward lane 0, preserving program order. Synchronous flush squashes all in-flight bundles.
// PARAMETERS
// - LANES   2   slots per bundle (1..4)
// - DATA_W  64  payload bits per slot (all per-stage fields packed by the stage owner)
// - CNT_W   32  width of perf counters (only used with PIPE_PERF_CNT_EN)
// PORTS
// - clk          in   1             clock, all state on posedge
// - resetn       in   1             reset, synchronous, active-low
// - flush        in   1             squash everything held and anything offered this cycle
// - in_valid     in   LANES         per-slot valid from upstream; bit i = slot i
// - in_data      in   LANES*DATA_W  slot i at [i*DATA_W +: DATA_W]
// - in_ready     out  1             registered; upstream bundle accepted when in_push
// - out_valid    out  LANES         per-slot valid to downstream, compacted (contiguous from bit 0)
// - out_data     out  LANES*DATA_W  payload; invalid slots driven all-zero
// - out_ready    in   1             downstream accepts bundle when out_pop
// - stall_cnt    out  CNT_W         [PIPE_PERF_CNT_EN] cycles with |out_valid && !out_ready
// - bubble_cnt   out  CNT_W         [PIPE_PERF_CNT_EN] cycles with out_valid==0
// BEHAVIOUR
// - in_push = |in_valid && in_ready && !flush.
// - out_pop = |out_valid && out_ready.
// - A bundle with in_valid==0 is never a transfer and never occupies an entry.
// - Compaction at capture: valid slots are packed to the lowest indices in ascending lane order; the remaining slots get valid=0, data=0.
//   - Example: in_valid=2'b10 is stored as valid=2'b01 with slot0 = old lane1 data.
// - Storage: MAIN (drives out_*) and SKID. States: EMPTY, ONE (MAIN valid), TWO (MAIN+SKID valid).
// - Transitions (no flush):
//   - EMPTY: push -> ONE, MAIN <= in. Otherwise stay.
//   - ONE:
//     - push & pop -> ONE, MAIN <= in.
//     - push & !pop -> TWO, SKID <= in.
//     - pop & !push -> EMPTY.
//   - TWO: push impossible (in_ready=0). pop -> ONE, MAIN <= SKID, SKID cleared.
// - in_ready next cycle = (next state != TWO). It is 1 out of reset.
// - Latency: a bundle pushed in cycle N is visible on out_* in cycle N+1 if MAIN is free or popped in N.
// - Throughput: 1 bundle/cycle while out_ready stays high.
// - Order: strict FIFO. SKID is never bypassed.
// - flush (priority below reset, above everything else):
//   - next state EMPTY, out_valid=0, out_data=0, SKID cleared, in_ready=1 next cycle.
//   - The input offered in the flush cycle is dropped.
//   - out_pop in the flush cycle still counts for downstream (the bundle is consumed, then cleared).
// - Reset (resetn=0 at posedge):
//   - state EMPTY, out_valid=0, out_data=0, SKID cleared, in_ready=1, counters 0.
//   - Reset mid-transfer discards both entries without handshake.
// - Invalid slots never propagate stale data: out_data slot is zero whenever its out_valid bit is 0.
// CONFIGURATION
// - PIPE_PERF_CNT_EN defined:
//   - stall_cnt and bubble_cnt ports exist.
//   - Each increments by 1 per qualifying cycle and saturates at all-ones.
//   - Both are cleared by reset only (not by flush).
// - PIPE_PERF_CNT_EN undefined: both ports and their counters are absent. All other behaviour is identical.
// TESTING
// - Reset: resetn=0 for 2 cycles -> out_valid=0, out_data=0, in_ready=1; counters=0 with PIPE_PERF_CNT_EN.
// - Streaming: out_ready=1, push bundles A,B,C on consecutive cycles -> out A,B,C in cycles N+1..N+3; in_ready stays 1.
// - Skid: out_ready=0, push A then B -> state TWO, in_ready=0 in cycle 3; raise out_ready -> A, then B, in consecutive cycles.
//   - C offered while in_ready=0 must not be captured.
// - Compaction: LANES=2, in_valid=2'b10, lane1=64'hDEAD -> out_valid=2'b01, slot0=64'hDEAD, slot1=0.
//   - in_valid=2'b00 -> no transfer, state unchanged.
// - Flush: state TWO, flush=1 with in_valid=2'b11 offered -> next cycle out_valid=0, out_data=0, in_ready=1; offered bundle absent.
// - Perf (PIPE_PERF_CNT_EN, CNT_W=4): hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=4'hF (saturated).

Source files
------------

// File: rtl/lane_skid_pipe_reg_if.sv
// Handshake bundle between pipeline stages: upstream slots in, compacted slots out.
// The slave modport is the pipe register's view; master is the driving stage/bench.
interface lane_skid_pipe_reg_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64
);
  logic [LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_ready;
  logic [LANES-1:0]        out_valid;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lane_skid_pipe_reg.sv
// Dual-entry skid pipeline register with lane compaction and synchronous flush.
// Optional perf counters (stall_cnt/bubble_cnt) are built when PIPE_PERF_CNT_EN is defined.
//
// state    | meaning
// EMPTY    | nothing held, out_valid=0
// ONE      | MAIN holds a bundle
// TWO      | MAIN and SKID hold bundles, in_ready=0
module lane_skid_pipe_reg #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  lane_skid_pipe_reg_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    bubble_cnt
`endif
);
  localparam int BW = LANES * DATA_W;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  state_e           state_q, state_d;
  logic [LANES-1:0] main_valid_q, main_valid_d;
  logic [BW-1:0]    main_data_q, main_data_d;
  logic [LANES-1:0] skid_valid_q, skid_valid_d;
  logic [BW-1:0]    skid_data_q, skid_data_d;
  logic             in_ready_q;

  logic [LANES-1:0] cmp_valid;
  logic [BW-1:0]    cmp_data;
  logic             push, pop;

  // Pack valid slots toward lane 0 in ascending order; unused slots stay zero.
  always_comb begin
    int slot;
    cmp_valid = '0;
    cmp_data  = '0;
    slot      = 0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_valid[i]) begin
        cmp_valid[slot]                     = 1'b1;
        cmp_data[slot*DATA_W +: DATA_W]     = bus.in_data[i*DATA_W +: DATA_W];
        slot++;
      end
    end
  end

  assign push = (|bus.in_valid) && in_ready_q && !flush;
  assign pop  = (|main_valid_q) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_EMPTY;
      main_valid_q <= '0;
      main_data_q  <= '0;
      skid_valid_q <= '0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_TWO;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = '0;
      main_data_d  = '0;
      skid_valid_d = '0;
      skid_data_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_valid_d = cmp_valid;
            main_data_d  = cmp_data;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_valid_d = cmp_valid;
            main_data_d  = cmp_data;
          end else if (push) begin
            skid_valid_d = cmp_valid;
            skid_data_d  = cmp_data;
          end else if (pop) begin
            main_valid_d = '0;
            main_data_d  = '0;
          end
        end
        ST_TWO: begin
          // SKID always drains through MAIN so order stays strict FIFO.
          if (pop) begin
            main_valid_d = skid_valid_q;
            main_data_d  = skid_data_q;
            skid_valid_d = '0;
            skid_data_d  = '0;
          end
        end
        default: begin
          main_valid_d = '0;
          main_data_d  = '0;
          skid_valid_d = '0;
          skid_data_d  = '0;
        end
      endcase
    end
  end

  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.in_ready  = in_ready_q;

`ifdef PIPE_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if ((|main_valid_q) && !bus.out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if ((main_valid_q == '0) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_lane_skid_pipe_reg.sv
// Self-checking bench for lane_skid_pipe_reg: directed scenarios plus randomized traffic
// compared against a queue-based FIFO model (capacity 2, compaction, flush, perf counters).
module tb_lane_skid_pipe_reg;
  localparam int L = 2;
  localparam int D = 64;
`ifdef PIPE_PERF_CNT_EN
  localparam int C = 4;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  lane_skid_pipe_reg_if #(.LANES(L), .DATA_W(D)) bus_if ();

`ifdef PIPE_PERF_CNT_EN
  logic [C-1:0] stall_cnt, bubble_cnt;
  logic [C-1:0] m_stall = '0, m_bubble = '0;
  lane_skid_pipe_reg #(.LANES(L), .DATA_W(D), .CNT_W(C)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus_if),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));
`else
  lane_skid_pipe_reg #(.LANES(L), .DATA_W(D)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus_if));
`endif

  always #5 clk = ~clk;

  // Reference model: FIFO of already-compacted bundles, at most two held.
  logic [L-1:0]   mq_v[$];
  logic [L*D-1:0] mq_d[$];

  function automatic logic [L-1:0] exp_valid();
    return (mq_v.size() > 0) ? mq_v[0] : '0;
  endfunction
  function automatic logic [L*D-1:0] exp_data();
    return (mq_d.size() > 0) ? mq_d[0] : '0;
  endfunction
  function automatic logic exp_ready();
    return mq_v.size() < 2;
  endfunction

  function automatic logic [L*D-1:0] rnd_bundle();
    logic [L*D-1:0] r;
    for (int i = 0; i < L*D; i += 32) r[i +: 32] = $urandom;
    return r;
  endfunction

  task automatic compact(input logic [L-1:0] iv, input logic [L*D-1:0] id,
                         output logic [L-1:0] cv, output logic [L*D-1:0] cd);
    logic [D-1:0] lanes[$];
    for (int i = 0; i < L; i++) if (iv[i]) lanes.push_back(id[i*D +: D]);
    cv = L'((1 << lanes.size()) - 1);
    cd = '0;
    for (int k = 0; k < lanes.size(); k++) cd[k*D +: D] = lanes[k];
  endtask

  // Drive one cycle of stimulus from a negedge, advance the model at the posedge.
  task automatic step(input logic fl, input logic [L-1:0] iv,
                      input logic [L*D-1:0] id, input logic ordy);
    logic push, pop;
    logic [L-1:0]   cv;
    logic [L*D-1:0] cd;
    flush = fl;
    bus_if.in_valid  = iv;
    bus_if.in_data   = id;
    bus_if.out_ready = ordy;
    push = (iv != '0) && exp_ready() && !fl;
    pop  = (mq_v.size() > 0) && ordy;
    compact(iv, id, cv, cd);
    @(posedge clk);
`ifdef PIPE_PERF_CNT_EN
    if (mq_v.size() > 0 && !ordy && m_stall != '1) m_stall++;
    if (mq_v.size() == 0 && m_bubble != '1) m_bubble++;
`endif
    if (fl) begin
      mq_v.delete();
      mq_d.delete();
    end else begin
      if (pop) begin
        void'(mq_v.pop_front());
        void'(mq_d.pop_front());
      end
      if (push) begin
        mq_v.push_back(cv);
        mq_d.push_back(cd);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    flush  = 1'b0;
    bus_if.in_valid  = 2'b11;
    bus_if.in_data   = rnd_bundle();
    bus_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    mq_v.delete();
    mq_d.delete();
`ifdef PIPE_PERF_CNT_EN
    m_stall  = '0;
    m_bubble = '0;
`endif
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    step(0, 2'b11, rnd_bundle(), 0);
    step(0, 2'b11, rnd_bundle(), 0);
    do_reset();
    checks++; if (bus_if.out_valid !== '0) begin errors++;
      $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid); end
    checks++; if (bus_if.out_data !== '0) begin errors++;
      $display("FAIL reset_out_data: got %h expected 0", bus_if.out_data); end
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready); end
`ifdef PIPE_PERF_CNT_EN
    checks++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin errors++;
      $display("FAIL reset_counters: got %h/%h expected 0/0", stall_cnt, bubble_cnt); end
`endif
  endtask

  task automatic test_streaming();
    logic [L*D-1:0] b[3];
    for (int k = 0; k < 3; k++) b[k] = rnd_bundle();
    for (int k = 0; k < 3; k++) begin
      step(0, 2'b11, b[k], 1);
      checks++; if (bus_if.out_valid !== 2'b11 || bus_if.out_data !== b[k]) begin errors++;
        $display("FAIL stream_out[%0d]: got %b/%h expected 11/%h", k, bus_if.out_valid, bus_if.out_data, b[k]); end
      checks++; if (bus_if.in_ready !== 1'b1) begin errors++;
        $display("FAIL stream_in_ready[%0d]: got %b expected 1", k, bus_if.in_ready); end
    end
    step(0, 2'b00, '0, 1);
    checks++; if (bus_if.out_valid !== '0) begin errors++;
      $display("FAIL stream_drain: got %b expected 0", bus_if.out_valid); end
  endtask

  task automatic test_skid();
    logic [L*D-1:0] a, b, c;
    a = rnd_bundle(); b = rnd_bundle(); c = rnd_bundle();
    step(0, 2'b11, a, 0);
    step(0, 2'b11, b, 0);
    checks++; if (bus_if.in_ready !== 1'b0 || bus_if.out_data !== a) begin errors++;
      $display("FAIL skid_full: got ready %b data %h expected 0/%h", bus_if.in_ready, bus_if.out_data, a); end
    step(0, 2'b11, c, 0);
    checks++; if (bus_if.in_ready !== 1'b0 || bus_if.out_data !== a) begin errors++;
      $display("FAIL skid_hold: got ready %b data %h expected 0/%h", bus_if.in_ready, bus_if.out_data, a); end
    step(0, 2'b00, '0, 1);
    checks++; if (bus_if.out_valid !== 2'b11 || bus_if.out_data !== b || bus_if.in_ready !== 1'b1) begin errors++;
      $display("FAIL skid_second: got %b/%h ready %b expected 11/%h ready 1", bus_if.out_valid, bus_if.out_data, bus_if.in_ready, b); end
    step(0, 2'b00, '0, 1);
    checks++; if (bus_if.out_valid !== '0 || bus_if.out_data !== '0) begin errors++;
      $display("FAIL skid_no_c: got %b/%h expected 0/0", bus_if.out_valid, bus_if.out_data); end
  endtask

  task automatic test_compaction();
    logic [L*D-1:0] in_b, want;
    in_b = rnd_bundle();
    in_b[D +: D] = 64'hDEAD;
    want = '0;
    want[0 +: D] = 64'hDEAD;
    step(0, 2'b10, in_b, 1);
    checks++; if (bus_if.out_valid !== 2'b01 || bus_if.out_data !== want) begin errors++;
      $display("FAIL compact: got %b/%h expected 01/%h", bus_if.out_valid, bus_if.out_data, want); end
    step(0, 2'b00, rnd_bundle(), 0);
    checks++; if (bus_if.out_valid !== 2'b01 || bus_if.out_data !== want || bus_if.in_ready !== 1'b1) begin errors++;
      $display("FAIL empty_bundle: got %b/%h ready %b expected 01/%h ready 1", bus_if.out_valid, bus_if.out_data, bus_if.in_ready, want); end
    step(0, 2'b00, '0, 1);
  endtask

  task automatic test_flush();
    step(0, 2'b11, rnd_bundle(), 0);
    step(0, 2'b01, rnd_bundle(), 0);
    step(1, 2'b11, rnd_bundle(), 0);
    checks++; if (bus_if.out_valid !== '0 || bus_if.out_data !== '0 || bus_if.in_ready !== 1'b1) begin errors++;
      $display("FAIL flush: got %b/%h ready %b expected 0/0 ready 1", bus_if.out_valid, bus_if.out_data, bus_if.in_ready); end
    step(0, 2'b00, '0, 1);
    checks++; if (bus_if.out_valid !== '0) begin errors++;
      $display("FAIL flush_dropped: got %b expected 0", bus_if.out_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      step(($urandom % 20) == 0, L'($urandom), rnd_bundle(), ($urandom % 3) != 0);
      checks++; if (bus_if.out_valid !== exp_valid() || bus_if.out_data !== exp_data()) begin errors++;
        $display("FAIL rand_out[%0d]: got %b/%h expected %b/%h", n, bus_if.out_valid, bus_if.out_data, exp_valid(), exp_data()); end
      checks++; if (bus_if.in_ready !== exp_ready()) begin errors++;
        $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, bus_if.in_ready, exp_ready()); end
`ifdef PIPE_PERF_CNT_EN
      checks++; if (stall_cnt !== m_stall || bubble_cnt !== m_bubble) begin errors++;
        $display("FAIL rand_counters[%0d]: got %h/%h expected %h/%h", n, stall_cnt, bubble_cnt, m_stall, m_bubble); end
`endif
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    step(0, 2'b11, rnd_bundle(), 0);
    checks++; if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h1) begin errors++;
      $display("FAIL perf_start: got %h/%h expected 0/1", stall_cnt, bubble_cnt); end
    repeat (20) step(0, 2'b00, '0, 0);
    checks++; if (stall_cnt !== 4'hF) begin errors++;
      $display("FAIL perf_stall_sat: got %h expected F", stall_cnt); end
    step(1, 2'b00, '0, 0);
    checks++; if (stall_cnt !== 4'hF || bubble_cnt !== 4'h1) begin errors++;
      $display("FAIL perf_flush_keeps: got %h/%h expected F/1", stall_cnt, bubble_cnt); end
  endtask
`endif

  initial begin
    bus_if.in_valid  = '0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    test_reset();
    test_streaming();
    test_skid();
    test_compaction();
    test_flush();
    test_random();
`ifdef PIPE_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
